dense_argmax: RTL
=================

DENSE_ARGMAX -- requirements
Module: dense_argmax

Interface
REQ-001 The block SHALL have parameter N_IN, default 1568, meaning pooled features per image (8 channels x 14 x 14).
REQ-002 The block SHALL have parameter N_OUT, default 10, meaning output classes.
REQ-003 The block SHALL have parameter ACC_W, default 26, meaning signed accumulator width.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to classify the stored feature map.
REQ-007 feat_addr  output  11  feature-memory read address.
REQ-008 feat_data  input  8  signed feature; valid one cycle after feat_addr.
REQ-009 w_addr  output  15  weight-ROM read address.
REQ-010 w_data  input  8  signed weight; valid one cycle after w_addr.
REQ-011 cls_idx  output  4  class currently being computed.
REQ-012 bias_data  input  8  signed bias for cls_idx; combinational.
REQ-013 busy  output  1  high from the cycle after start is accepted until done.
REQ-014 done  output  1  one-cycle pulse when the result is valid.
REQ-015 class_out  output  4  winning class index; held until the next accepted start.
REQ-016 max_score  output  ACC_W  winning score, signed; held with class_out.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, FINAL and DONE.
REQ-018 In IDLE with start=1, the FSM SHALL go to RUN, clear cls_idx, the feature index i, w_addr and the accumulator, and clear best-valid.
REQ-019 In RUN, each cycle SHALL drive feat_addr=i and w_addr=cls_idx*N_IN+i; w_addr SHALL come from a running counter, not a multiplier.
REQ-020 In RUN, a one-cycle valid delay SHALL qualify data, and acc += sext(feat_data)*sext(w_data) on each qualified cycle.
REQ-021 After issuing i=N_IN-1, the FSM SHALL go to DRAIN, which accumulates the last product with no new address.
REQ-022 In FINAL, score = acc + sext(bias_data).
REQ-023 In FINAL, if best-valid=0 or score > best (strict, signed), the block SHALL take best=score and best_idx=cls_idx; ties SHALL keep the lower index.
REQ-024 From FINAL, if cls_idx<N_OUT-1, the block SHALL increment cls_idx, clear acc and i, and return to RUN; otherwise it SHALL go to DONE.
REQ-025 In DONE, done=1 for one cycle and class_out/max_score SHALL load from best; the FSM SHALL then go to IDLE.
REQ-026 Latency: per class N_IN+2 cycles; done SHALL be high exactly N_OUT*(N_IN+2)+1 cycles after the edge that sampled start.
REQ-027 start SHALL be ignored while busy=1 or in DONE.
REQ-028 ACC_W SHALL hold N_IN*128*128 without overflow; no saturation logic; an elaboration check SHALL flag ACC_W too small.
REQ-029 feat_addr and w_addr SHALL hold 0 outside RUN.

Reset
REQ-030 On rst_n=0 at a clock edge, the FSM SHALL enter IDLE regardless of state, including mid-RUN; a partial result SHALL be discarded with no done pulse.
REQ-031 Reset values SHALL be: busy=0, done=0, class_out=0, max_score=0, cls_idx=0, feat_addr=0, w_addr=0, acc=0, best-valid=0.

Structure
REQ-032 A shared package cnn_pkg SHALL hold the N_IN, N_OUT and ACC_W defaults, the address widths and the FSM state typedef.
REQ-033 The block SHALL contain one sub-module, argmax_tracker (best/best_idx/best-valid register, compare, tie rule).
REQ-034 Total RTL SHALL be 120-400 lines.

Verification (N_IN=4, N_OUT=3 unless stated)
REQ-035 All feats 1, weights class k = k+1, biases 0 -> scores 4,8,12; class_out=2, max_score=12, done at cycle 3*6+1=19.
REQ-036 Scores equal (all weights 2) -> class_out=0 (tie keeps lowest).
REQ-037 Feats -128, weights 127 for class 1, others 0; bias class 0 = -5 -> class_out=2, max_score=0; class 1 score -65024 handled signed.
REQ-038 rst_n low for 1 cycle mid-RUN of class 1, then start -> no done before restart; result equals the clean run.
REQ-039 start pulsed every cycle during busy -> exactly one done per accepted start.
REQ-040 Full size N_IN=1568, N_OUT=10, random data vs golden model -> matching class_out/max_score; worst-case all -128 x -128 -> max_score=25690112, no overflow.

Source files
------------

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the dense-layer / argmax classifier:
//   - default geometry (N_IN, N_OUT, ACC_W)
//   - fixed address / index / data widths used on the block ports
//   - FSM state encoding
//   - acc_bits_needed(): minimum signed accumulator width for a given N_IN
// No ports (package).
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int N_IN_DEF  = 1568;   // 8 channels x 14 x 14 pooled features
    localparam int N_OUT_DEF = 10;     // output classes
    localparam int ACC_W_DEF = 26;     // signed accumulator width

    localparam int FA_W   = 11;        // feature-memory address width
    localparam int WA_W   = 15;        // weight-ROM address width
    localparam int CLS_W  = 4;         // class index width
    localparam int DATA_W = 8;         // feature / weight / bias width
    localparam int PROD_W = 16;        // 8x8 signed product width

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RUN   = 3'd1;
    localparam state_t ST_DRAIN = 3'd2;
    localparam state_t ST_FINAL = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Worst-case magnitude is N_IN * 128 * 128 (every product -128 x -128);
    // one extra bit carries the sign.
    function automatic int acc_bits_needed(input int n_in);
        longint max_mag;
        max_mag = longint'(n_in) * 64'sd16384;
        return $clog2(max_mag + 64'sd1) + 1;
    endfunction

endpackage

// File: rtl/argmax_tracker.sv
// -----------------------------------------------------------------------------
// argmax_tracker
// Holds the best score seen so far, its class index and a valid flag.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clr             start of a new classification: drop the current best
//   upd             a finished class score is presented on score/idx
//   score, idx      candidate score (signed) and its class index
//   best, best_idx  current winner
//   best_valid      at least one class has been compared since clr
// A candidate wins only when strictly greater, so ties keep the lower index
// (classes are presented in ascending order).
// -----------------------------------------------------------------------------
module argmax_tracker
    import cnn_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    upd,
    input  logic signed [ACC_W-1:0] score,
    input  logic [CLS_W-1:0]        idx,
    output logic signed [ACC_W-1:0] best,
    output logic [CLS_W-1:0]        best_idx,
    output logic                    best_valid
);

    logic signed [ACC_W-1:0] best_r;
    logic [CLS_W-1:0]        best_idx_r;
    logic                    best_valid_r;
    logic                    take_s;

    // Decide whether the candidate replaces the current best.
    always_comb begin
        take_s = 1'b0;
        if (!best_valid_r) begin
            take_s = 1'b1;
        end else if (score > best_r) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // Best-score register with clear on new request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_r       <= '0;
            best_idx_r   <= '0;
            best_valid_r <= 1'b0;
        end else if (clr) begin
            best_r       <= '0;
            best_idx_r   <= '0;
            best_valid_r <= 1'b0;
        end else if (upd && take_s) begin
            best_r       <= score;
            best_idx_r   <= idx;
            best_valid_r <= 1'b1;
        end
    end

    assign best       = best_r;
    assign best_idx   = best_idx_r;
    assign best_valid = best_valid_r;

endmodule

// File: rtl/dense_argmax.sv
// -----------------------------------------------------------------------------
// dense_argmax
// Fully connected layer followed by argmax. For each class the block streams
// N_IN features and weights through a MAC, adds the class bias and keeps the
// highest-scoring class.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            one-cycle request (ignored while busy / in DONE)
//   feat_addr/data   feature memory read port, data one cycle after address
//   w_addr/data      weight ROM read port, data one cycle after address
//   cls_idx          class being computed; bias_data is combinational on it
//   busy             request in progress
//   done             one-cycle result strobe
//   class_out        winning class, held until next accepted start
//   max_score        winning score (signed), held with class_out
// Per class: N_IN RUN cycles, one DRAIN cycle (last product), one FINAL cycle
// (bias + compare).
// -----------------------------------------------------------------------------
module dense_argmax
    import cnn_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [FA_W-1:0]          feat_addr,
    input  logic signed [DATA_W-1:0] feat_data,
    output logic [WA_W-1:0]          w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    output logic [CLS_W-1:0]         cls_idx,
    input  logic signed [DATA_W-1:0] bias_data,
    output logic                     busy,
    output logic                     done,
    output logic [CLS_W-1:0]         class_out,
    output logic signed [ACC_W-1:0]  max_score
);

    if (ACC_W < acc_bits_needed(N_IN)) begin : g_acc_w_check
        $error("dense_argmax: ACC_W too small to hold N_IN*128*128");
    end

    state_t                  state_r;
    logic [FA_W-1:0]         i_r;        // feature index, doubles as feat_addr
    logic [WA_W-1:0]         w_addr_r;   // running weight address
    logic [WA_W-1:0]         w_base_r;   // where the next class's weights start
    logic [CLS_W-1:0]        cls_r;
    logic                    valid_r;    // data on feat_data/w_data belongs to us
    logic signed [ACC_W-1:0] acc_r;
    logic                    busy_r;
    logic                    done_r;
    logic [CLS_W-1:0]        class_out_r;
    logic signed [ACC_W-1:0] max_score_r;

    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  score_s;
    logic signed [ACC_W-1:0]  best_s;
    logic [CLS_W-1:0]         best_idx_s;
    logic                     best_valid_s;
    logic                     accept_s;
    logic                     final_s;

    assign prod_s   = PROD_W'(feat_data) * PROD_W'(w_data);
    assign score_s  = acc_r + ACC_W'(bias_data);
    assign accept_s = (state_r == ST_IDLE) && start;
    assign final_s  = (state_r == ST_FINAL);

    argmax_tracker #(
        .ACC_W (ACC_W)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (accept_s),
        .upd        (final_s),
        .score      (score_s),
        .idx        (cls_r),
        .best       (best_s),
        .best_idx   (best_idx_s),
        .best_valid (best_valid_s)
    );

    // Sequencer, MAC accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            i_r         <= '0;
            w_addr_r    <= '0;
            w_base_r    <= '0;
            cls_r       <= '0;
            valid_r     <= 1'b0;
            acc_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            class_out_r <= '0;
            max_score_r <= '0;
        end else begin
            done_r  <= 1'b0;
            valid_r <= (state_r == ST_RUN);
            if (valid_r) begin
                acc_r <= acc_r + ACC_W'(prod_s);
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_RUN;
                        busy_r   <= 1'b1;
                        cls_r    <= '0;
                        i_r      <= '0;
                        w_addr_r <= '0;
                        w_base_r <= '0;
                        acc_r    <= '0;
                    end
                end
                ST_RUN: begin
                    if (i_r == FA_W'(N_IN - 1)) begin
                        // Addresses drop to 0; remember the next class base.
                        state_r  <= ST_DRAIN;
                        i_r      <= '0;
                        w_addr_r <= '0;
                        w_base_r <= w_addr_r + WA_W'(1);
                    end else begin
                        i_r      <= i_r + FA_W'(1);
                        w_addr_r <= w_addr_r + WA_W'(1);
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_FINAL;
                end
                ST_FINAL: begin
                    // valid_r is low here, so clearing acc cannot drop a product.
                    if (cls_r < CLS_W'(N_OUT - 1)) begin
                        state_r  <= ST_RUN;
                        cls_r    <= cls_r + CLS_W'(1);
                        acc_r    <= '0;
                        i_r      <= '0;
                        w_addr_r <= w_base_r;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    class_out_r <= best_idx_s;
                    max_score_r <= best_s;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign feat_addr = i_r;
    assign w_addr    = w_addr_r;
    assign cls_idx   = cls_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign class_out = class_out_r;
    assign max_score = max_score_r;

endmodule
